ct_had_ifu_dbginfo_rd: RTL and testbench

CT_HAD_IFU_DBGINFO_RD -- requirements
Module: ct_had_ifu_dbginfo_rd

---
 rtl/ct_had_ifu_dbginfo_rd_pkg.sv | 36 +++
 rtl/ct_had_ifu_dbginfo_rd_wmux.sv | 38 +++
 rtl/ct_had_ifu_dbginfo_rd.sv | 132 +++++++++++++
 tb/tb_ct_had_ifu_dbginfo_rd.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_had_ifu_dbginfo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module : ct_had_ifu_dbginfo_rd_pkg
// Brief  : Shared HAD definitions for the IFU debug-info snapshot reader.
// Rev    : 1.0  initial release
// ============================================================================
package ct_had_ifu_dbginfo_rd_pkg;

  localparam int INFO_W_DEF  = 83;
  localparam int TMO_CYC_DEF = 255;

  // 2'b11 is illegal and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_READY = 2'b10
  } dbg_state_e;

  localparam logic [1:0] IDX_W0 = 2'd0;
  localparam logic [1:0] IDX_W1 = 2'd1;
  localparam logic [1:0] IDX_W2 = 2'd2;
  localparam logic [1:0] IDX_W3 = 2'd3;

  localparam int PC_BUS_MSB = 82;
  localparam int PC_BUS_LSB = 69;
  localparam int STALL_MSB  = 68;
  localparam int STALL_LSB  = 52;
  localparam int VALID_MSB  = 51;
  localparam int VALID_LSB  = 36;
  localparam int FSM_MSB    = 35;
  localparam int FSM_LSB    = 3;
  localparam int VFDSU_MSB  = 2;
  localparam int VFDSU_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/ct_had_ifu_dbginfo_rd_wmux.sv
`default_nettype none
// ============================================================================
// Module : ct_had_dbginfo_wmux
// Brief  : Combinational snapshot-to-32-bit word select with error flag.
// Rev    : 1.0  initial release
// ============================================================================
module ct_had_dbginfo_wmux
  import ct_had_ifu_dbginfo_rd_pkg::*;
#(
  parameter int INFO_W = INFO_W_DEF
) (
  input  logic [INFO_W-1:0] i_snap,
  input  logic [1:0]        i_idx,
  input  logic              i_ready,
  output logic [31:0]       o_data,
  output logic              o_err
);

  localparam int EXT_W = 96;

  logic [EXT_W-1:0] w_ext;
  assign w_ext = {{(EXT_W-INFO_W){1'b0}}, i_snap};

  always_comb begin
    o_data = '0;
    o_err  = 1'b1;
    if (i_ready) begin
      case (i_idx)
        IDX_W0: begin o_data = w_ext[31:0];  o_err = 1'b0; end
        IDX_W1: begin o_data = w_ext[63:32]; o_err = 1'b0; end
        IDX_W2: begin o_data = w_ext[95:64]; o_err = 1'b0; end
        default: begin o_data = '0;          o_err = 1'b1; end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ct_had_ifu_dbginfo_rd.sv
`default_nettype none
// ============================================================================
// Module : ct_had_ifu_dbginfo_rd
// Brief  : Captures the IFU debug snapshot on debug entry and serves reads.
// Rev    : 1.0  initial release
// ============================================================================
module ct_had_ifu_dbginfo_rd
  import ct_had_ifu_dbginfo_rd_pkg::*;
#(
  parameter int INFO_W  = INFO_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              had_rtu_xx_jdbreq,
  input  logic              rtu_had_xx_dbgon,
  input  logic [INFO_W-1:0] ifu_had_debug_info,
  input  logic              ifu_had_reset_on,
  input  logic              regs_dbginfo_clr,
  input  logic              regs_dbginfo_rd_req,
  input  logic [1:0]        regs_dbginfo_rd_idx,
  output logic              dbginfo_regs_rd_ack,
  output logic [31:0]       dbginfo_regs_rd_data,
  output logic              dbginfo_regs_rd_err,
  output logic              dbginfo_regs_vld,
  output logic              dbginfo_regs_tmo,
  output logic              dbginfo_regs_rst_seen
);

  dbg_state_e        r_state;
  dbg_state_e        w_nxt;
  logic [7:0]        r_cnt;
  logic [INFO_W-1:0] r_snap;
  logic              r_jdbreq_d;
  logic              r_vld;
  logic              r_tmo;
  logic              r_rst_seen;
  logic              r_ack;
  logic [31:0]       r_data;
  logic              r_err;
  logic              w_rise;
  logic              w_capture;
  logic              w_timeout;
  logic              w_tmo_clr;
  logic [31:0]       w_mux_data;
  logic              w_mux_err;

  assign w_rise = had_rtu_xx_jdbreq & ~r_jdbreq_d;

  always_comb begin
    w_nxt     = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (had_rtu_xx_jdbreq) w_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rtu_had_xx_dbgon) begin
          w_nxt     = ST_READY;
          w_capture = 1'b1;
        end else if (r_cnt == 8'(TMO_CYC)) begin
          w_nxt     = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_READY: begin
        // a fresh request outranks a coincident clear
        if (w_rise)                w_nxt = ST_WAIT;
        else if (regs_dbginfo_clr) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_tmo_clr = (w_rise && r_state != ST_WAIT) ||
                     (regs_dbginfo_clr && (r_state == ST_IDLE || r_state == ST_WAIT));

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_snap     <= '0;
      r_jdbreq_d <= 1'b0;
      r_vld      <= 1'b0;
      r_tmo      <= 1'b0;
      r_rst_seen <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_jdbreq_d <= had_rtu_xx_jdbreq;
      r_vld      <= (w_nxt == ST_READY);
      r_cnt      <= (r_state == ST_WAIT) ? r_cnt + 8'd1 : 8'd0;
      if (w_capture) r_snap <= ifu_had_debug_info;
      if (w_timeout)      r_tmo <= 1'b1;
      else if (w_tmo_clr) r_tmo <= 1'b0;
      if (ifu_had_reset_on)      r_rst_seen <= 1'b1;
      else if (regs_dbginfo_clr) r_rst_seen <= 1'b0;
    end
  end

  // decode uses the registered state, so a read racing a capture errors
  ct_had_dbginfo_wmux #(
    .INFO_W (INFO_W)
  ) u_wmux (
    .i_snap  (r_snap),
    .i_idx   (regs_dbginfo_rd_idx),
    .i_ready (r_state == ST_READY),
    .o_data  (w_mux_data),
    .o_err   (w_mux_err)
  );

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_ack  <= 1'b0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_ack  <= regs_dbginfo_rd_req;
      r_data <= regs_dbginfo_rd_req ? w_mux_data : 32'd0;
      r_err  <= regs_dbginfo_rd_req & w_mux_err;
    end
  end

  assign dbginfo_regs_rd_ack   = r_ack;
  assign dbginfo_regs_rd_data  = r_data;
  assign dbginfo_regs_rd_err   = r_err;
  assign dbginfo_regs_vld      = r_vld;
  assign dbginfo_regs_tmo      = r_tmo;
  assign dbginfo_regs_rst_seen = r_rst_seen;

endmodule
`default_nettype wire

// File: tb/tb_ct_had_ifu_dbginfo_rd.sv
`default_nettype none
// ============================================================================
// Module : tb_ct_had_ifu_dbginfo_rd
// Brief  : Directed and randomized checks against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ct_had_ifu_dbginfo_rd;

  localparam int S_IDLE = 0, S_WAIT = 1, S_READY = 2;
  localparam logic [82:0] CAP_INFO = 83'h1_2345_6789_ABCD_EF01_2345;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jdb = 1'b0, dbgon = 1'b0, rst_on = 1'b0, clr = 1'b0, rd = 1'b0;
  logic [82:0] info = '0;
  logic [1:0]  idx = 2'd0;
  logic        ack, err, vld, tmo, rs;
  logic [31:0] data;

  int n_cmp = 0;
  int n_fail = 0;

  int          m_state, m_cnt;
  logic [82:0] m_snap;
  logic        m_vld, m_tmo, m_rs, m_prev;
  logic        e_ack, e_err;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  ct_had_ifu_dbginfo_rd dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .had_rtu_xx_jdbreq     (jdb),
    .rtu_had_xx_dbgon      (dbgon),
    .ifu_had_debug_info    (info),
    .ifu_had_reset_on      (rst_on),
    .regs_dbginfo_clr      (clr),
    .regs_dbginfo_rd_req   (rd),
    .regs_dbginfo_rd_idx   (idx),
    .dbginfo_regs_rd_ack   (ack),
    .dbginfo_regs_rd_data  (data),
    .dbginfo_regs_rd_err   (err),
    .dbginfo_regs_vld      (vld),
    .dbginfo_regs_tmo      (tmo),
    .dbginfo_regs_rst_seen (rs)
  );

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_snap = '0;
    m_vld = 0; m_tmo = 0; m_rs = 0; m_prev = 0;
    e_ack = 0; e_err = 0; e_data = '0;
  endtask

  // Advance one clock: model consumes the driven inputs, then sample point.
  task automatic tick();
    logic rise, hit;
    int   ns;
    rise = jdb & ~m_prev;
    hit  = 1'b0;
    e_ack = rd; e_data = '0; e_err = 1'b0;
    if (rd) begin
      if (m_state == S_READY && idx != 2'd3) e_data = 32'(m_snap >> (32 * idx));
      else e_err = 1'b1;
    end
    ns = m_state;
    if (m_state == S_IDLE) begin
      if (jdb) ns = S_WAIT;
    end else if (m_state == S_WAIT) begin
      if (dbgon) begin ns = S_READY; m_snap = info; end
      else if (m_cnt == 255) begin ns = S_IDLE; hit = 1'b1; end
    end else begin
      if (rise) ns = S_WAIT;
      else if (clr) ns = S_IDLE;
    end
    if (clr && m_state != S_READY) m_tmo = 1'b0;
    if (rise && m_state != S_WAIT) m_tmo = 1'b0;
    if (hit) m_tmo = 1'b1;
    if (rst_on) m_rs = 1'b1; else if (clr) m_rs = 1'b0;
    m_cnt   = (m_state == S_WAIT) ? m_cnt + 1 : 0;
    m_state = ns;
    m_vld   = (ns == S_READY);
    m_prev  = jdb;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, data, err, vld, tmo, rs} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got ack=%b data=%h err=%b vld=%b tmo=%b rs=%b, want all 0", ack, data, err, vld, tmo, rs);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({ack, data, err, vld, tmo, rs} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_release: got ack=%b data=%h err=%b vld=%b tmo=%b rs=%b, want all 0", ack, data, err, vld, tmo, rs);
    end
  endtask

  task automatic test_capture();
    logic [31:0] want [3];
    want[0] = 32'hEF012345; want[1] = 32'h6789ABCD; want[2] = 32'h00012345;
    jdb = 1'b1; dbgon = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (vld !== 1'b0) begin n_fail++; $display("FAIL cap_wait_vld: got %b want 0", vld); end
    dbgon = 1'b1; info = CAP_INFO;
    tick();
    dbgon = 1'b0; info = 83'(~CAP_INFO);
    n_cmp++;
    if (vld !== 1'b1) begin n_fail++; $display("FAIL cap_vld: got %b want 1", vld); end
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; idx = 2'(i);
      tick();
      n_cmp++;
      if (ack !== 1'b1 || err !== 1'b0 || data !== want[i]) begin
        n_fail++;
        $display("FAIL cap_read%0d: got ack=%b err=%b data=%h want ack=1 err=0 data=%h", i, ack, err, data, want[i]);
      end
    end
    rd = 1'b0;
    tick();
    n_cmp++;
    if (ack !== 1'b0 || data !== 32'd0 || vld !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_idle_bus: got ack=%b data=%h vld=%b want ack=0 data=0 vld=1", ack, data, vld);
    end
    jdb = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [82:0] snap;
    logic [31:0] want;
    clr = 1'b1; tick(); clr = 1'b0;
    snap = 83'({$urandom, $urandom, $urandom});
    jdb = 1'b1; tick(); jdb = 1'b0;
    dbgon = 1'b1; info = snap; tick(); dbgon = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; idx = 2'(i);
      tick();
      want = (i == 0) ? snap[31:0] : (i == 1) ? snap[63:32] : (i == 2) ? {13'd0, snap[82:64]} : 32'd0;
      n_cmp++;
      if (ack !== 1'b1 || data !== want || err !== (i == 3)) begin
        n_fail++;
        $display("FAIL b2b_read%0d: got ack=%b err=%b data=%h want ack=1 err=%b data=%h", i, ack, err, data, (i == 3), want);
      end
    end
    rd = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    clr = 1'b1; tick(); clr = 1'b0;
    jdb = 1'b1; tick(); jdb = 1'b0;
    repeat (255) tick();
    n_cmp++;
    if (tmo !== 1'b0 || vld !== 1'b0) begin
      n_fail++; $display("FAIL tmo_early: got tmo=%b vld=%b want tmo=0 vld=0", tmo, vld);
    end
    tick();
    n_cmp++;
    if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", tmo); end
    rd = 1'b1; idx = 2'd0; tick(); rd = 1'b0;
    n_cmp++;
    if (ack !== 1'b1 || err !== 1'b1 || data !== 32'd0) begin
      n_fail++; $display("FAIL tmo_read: got ack=%b err=%b data=%h want ack=1 err=1 data=0", ack, err, data);
    end
  endtask

  task automatic test_boundary();
    jdb = 1'b1; tick(); jdb = 1'b0;
    n_cmp++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL bnd_tmo_clear: got %b want 0", tmo); end
    repeat (255) tick();
    dbgon = 1'b1; info = 83'({$urandom, $urandom, $urandom});
    tick();
    dbgon = 1'b0;
    n_cmp++;
    if (vld !== 1'b1 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL bnd_capture: got vld=%b tmo=%b want vld=1 tmo=0", vld, tmo);
    end
    rd = 1'b1; idx = 2'd3; tick(); rd = 1'b0;
    n_cmp++;
    if (ack !== 1'b1 || err !== 1'b1 || data !== 32'd0) begin
      n_fail++; $display("FAIL bnd_idx3: got ack=%b err=%b data=%h want ack=1 err=1 data=0", ack, err, data);
    end
  endtask

  task automatic test_race();
    jdb = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    n_cmp++;
    if (vld !== 1'b0) begin n_fail++; $display("FAIL race_vld: got %b want 0", vld); end
    jdb = 1'b0; dbgon = 1'b1; tick(); dbgon = 1'b0;
    n_cmp++;
    if (vld !== 1'b1) begin n_fail++; $display("FAIL race_recapture: got vld=%b want 1", vld); end
    clr = 1'b1; tick(); clr = 1'b0;
    rd = 1'b1; idx = 2'd1; tick(); rd = 1'b0;
    n_cmp++;
    if (vld !== 1'b0 || ack !== 1'b1 || err !== 1'b1 || data !== 32'd0) begin
      n_fail++; $display("FAIL race_idle_read: got vld=%b ack=%b err=%b data=%h want 0 1 1 0", vld, ack, err, data);
    end
  endtask

  task automatic test_rst_seen();
    rst_on = 1'b1; tick(); rst_on = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (rs !== 1'b1) begin n_fail++; $display("FAIL rs_sticky: got %b want 1", rs); end
    rst_on = 1'b1; clr = 1'b1; tick(); rst_on = 1'b0;
    n_cmp++;
    if (rs !== 1'b1) begin n_fail++; $display("FAIL rs_set_wins: got %b want 1", rs); end
    tick(); clr = 1'b0;
    n_cmp++;
    if (rs !== 1'b0) begin n_fail++; $display("FAIL rs_clear: got %b want 0", rs); end
  endtask

  task automatic test_reset_mid();
    rst_on = 1'b1; jdb = 1'b1; tick(); rst_on = 1'b0;
    rd = 1'b1; idx = 2'd0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({ack, data, err, vld, tmo, rs} !== 37'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ack=%b data=%h err=%b vld=%b tmo=%b rs=%b want all 0", ack, data, err, vld, tmo, rs);
    end
    @(posedge clk); #1;
    rd = 1'b0; jdb = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({ack, data, err, vld, tmo, rs} !== 37'd0) begin
      n_fail++;
      $display("FAIL rstmid_noack: got ack=%b data=%h err=%b vld=%b tmo=%b rs=%b want all 0", ack, data, err, vld, tmo, rs);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) jdb = ~jdb;
      dbgon  = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      rst_on = ($urandom_range(0, 49) == 0);
      rd     = 1'($urandom_range(0, 1));
      idx    = 2'($urandom_range(0, 3));
      info   = 83'({$urandom, $urandom, $urandom});
      tick();
      n_cmp++;
      if ({ack, err, vld, tmo, rs} !== {e_ack, e_err, m_vld, m_tmo, m_rs} || data !== e_data) begin
        n_fail++;
        $display("FAIL rand_c%0d: got ack=%b err=%b vld=%b tmo=%b rs=%b data=%h want ack=%b err=%b vld=%b tmo=%b rs=%b data=%h",
                 c, ack, err, vld, tmo, rs, data, e_ack, e_err, m_vld, m_tmo, m_rs, e_data);
      end
    end
    jdb = 1'b0; dbgon = 1'b0; clr = 1'b0; rst_on = 1'b0; rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_back_to_back();
    test_timeout();
    test_boundary();
    test_race();
    test_rst_seen();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
